// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
// Holds the FSM encoding, the stage-control bundle and the canned control patterns.
package pipe_ctrl_pkg;

    localparam int unsigned MEM_TIMEOUT_DEF  = 256;
    localparam int unsigned DRAIN_CYCLES_DEF = 3;
    localparam int unsigned CNT_W_DEF        = 64;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_DMEM_WAIT = 2'd1,
        ST_DRAIN     = 2'd2,
        ST_HALTED    = 2'd3
    } pipe_state_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_DEFAULT = '{
        pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_flush: 1'b0};

    localparam stage_ctrl_t CTRL_IDLE = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b0,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_flush: 1'b0};

    // Everything up to MEM freezes; WB keeps retiring and receives a bubble.
    localparam stage_ctrl_t CTRL_DMEM_STALL = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_flush: 1'b1};

    localparam stage_ctrl_t CTRL_BRANCH = '{
        pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
        if_id_flush: 1'b1, id_ex_flush: 1'b1, mem_wb_flush: 1'b0};

    localparam stage_ctrl_t CTRL_BUBBLE = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b1, mem_wb_flush: 1'b0};

    localparam stage_ctrl_t CTRL_DRAIN = '{
        pc_en: 1'b0, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
        if_id_flush: 1'b1, id_ex_flush: 1'b0, mem_wb_flush: 1'b0};

endpackage

// File: rtl/pipeline_control_unit_perf_counter.sv
// Saturating event counter used for the cycle, stall and flush statistics.
module perf_counter #(
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: hold at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_control_unit.sv
// Stall/flush sequencer for the 5-stage pipeline: merges hazard, branch, memory-wait
// and halt requests into stage enables/flushes, with drain/halt FSM and DMEM watchdog.
module pipeline_control_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT  = MEM_TIMEOUT_DEF,
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_stall,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             halted,
    output logic             bus_error,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned DRN_W  = $clog2(DRAIN_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [DRN_W-1:0]  DRN_ONE  = DRN_W'(1);
    localparam logic [DRN_W-1:0]  DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);

    pipe_state_t       state_q, state_d, eff_state_s;
    logic              ret_drain_q, ret_drain_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [DRN_W-1:0]  drain_q, drain_d;
    logic              bus_err_q, bus_err_d;
    stage_ctrl_t       ctrl_s, ctrl_out_s;
    logic              dmem_stall_s;
    logic              br_flush_s;
    logic              cyc_inc_s, stall_inc_s;

    assign dmem_stall_s = dmem_req && !dmem_ready;

    // On the release cycle the saved return state takes over so held requests act at once.
    always_comb begin
        if ((state_q == ST_DMEM_WAIT) && dmem_ready) begin
            eff_state_s = ret_drain_q ? ST_DRAIN : ST_RUN;
        end else begin
            eff_state_s = state_q;
        end
    end

    // Control decode and next-state logic.
    always_comb begin
        ctrl_s      = CTRL_DEFAULT;
        state_d     = eff_state_s;
        ret_drain_d = ret_drain_q;
        wait_d      = wait_q;
        drain_d     = drain_q;
        bus_err_d   = bus_err_q;
        br_flush_s  = 1'b0;
        case (eff_state_s)
            ST_RUN: begin
                if (dmem_stall_s) begin
                    ctrl_s      = CTRL_DMEM_STALL;
                    state_d     = ST_DMEM_WAIT;
                    ret_drain_d = 1'b0;
                    wait_d      = WAIT_ONE;
                end else if (branch_taken) begin
                    ctrl_s     = CTRL_BRANCH;
                    br_flush_s = 1'b1;
                end else if (!imem_ready) begin
                    ctrl_s = CTRL_BUBBLE;
                end else if (halt_req) begin
                    ctrl_s  = CTRL_DRAIN;
                    state_d = ST_DRAIN;
                    drain_d = {DRN_W{1'b0}};
                end else if (load_use_stall) begin
                    ctrl_s = CTRL_BUBBLE;
                end else begin
                    ctrl_s = CTRL_DEFAULT;
                end
            end
            ST_DRAIN: begin
                if (dmem_stall_s) begin
                    ctrl_s      = CTRL_DMEM_STALL;
                    state_d     = ST_DMEM_WAIT;
                    ret_drain_d = 1'b1;
                    wait_d      = WAIT_ONE;
                end else if (drain_q >= DRN_LAST) begin
                    ctrl_s  = CTRL_DRAIN;
                    state_d = ST_HALTED;
                    drain_d = {DRN_W{1'b0}};
                end else begin
                    ctrl_s  = CTRL_DRAIN;
                    drain_d = drain_q + DRN_ONE;
                end
            end
            ST_DMEM_WAIT: begin
                ctrl_s = CTRL_DMEM_STALL;
                wait_d = wait_q + WAIT_ONE;
                if (wait_d >= WAIT_MAX) begin
                    state_d   = ST_HALTED;
                    bus_err_d = 1'b1;
                end else begin
                    state_d = ST_DMEM_WAIT;
                end
            end
            ST_HALTED: begin
                ctrl_s = CTRL_IDLE;
                if (resume) begin
                    state_d   = ST_RUN;
                    bus_err_d = 1'b0;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            default: begin
                ctrl_s  = CTRL_IDLE;
                state_d = ST_RUN;
            end
        endcase
    end

    // FSM, watchdog, drain counter and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            ret_drain_q <= 1'b0;
            wait_q      <= {WAIT_W{1'b0}};
            drain_q     <= {DRN_W{1'b0}};
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_drain_q <= ret_drain_d;
            wait_q      <= wait_d;
            drain_q     <= drain_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Enables are forced low while reset is held, independent of any clock edge.
    assign ctrl_out_s   = rst_n ? ctrl_s : CTRL_IDLE;
    assign pc_en        = ctrl_out_s.pc_en;
    assign if_id_en     = ctrl_out_s.if_id_en;
    assign id_ex_en     = ctrl_out_s.id_ex_en;
    assign ex_mem_en    = ctrl_out_s.ex_mem_en;
    assign mem_wb_en    = ctrl_out_s.mem_wb_en;
    assign if_id_flush  = ctrl_out_s.if_id_flush;
    assign id_ex_flush  = ctrl_out_s.id_ex_flush;
    assign mem_wb_flush = ctrl_out_s.mem_wb_flush;
    assign halted       = (state_q == ST_HALTED);
    assign bus_error    = bus_err_q;

    assign cyc_inc_s   = (state_q != ST_HALTED);
    assign stall_inc_s = (state_q != ST_HALTED) && !ctrl_s.pc_en;

    perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .inc_i   (cyc_inc_s),
        .cnt_o   (cycle_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .inc_i   (stall_inc_s),
        .cnt_o   (stall_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .inc_i   (br_flush_s),
        .cnt_o   (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench for pipeline_control_unit with a short DMEM timeout.
module tb_pipeline_control_unit;

    localparam int CNT_W = 64;

    // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id/id_ex/mem_wb flushes}
    localparam logic [7:0] C_DEF = 8'b11111_000;
    localparam logic [7:0] C_BUB = 8'b00111_010;
    localparam logic [7:0] C_BR  = 8'b11111_110;
    localparam logic [7:0] C_DMW = 8'b00001_001;
    localparam logic [7:0] C_DRN = 8'b01111_100;
    localparam logic [7:0] C_HLT = 8'b00000_000;

    logic clk;
    logic rst_n;
    logic load_use_stall, branch_taken, imem_ready, dmem_req, dmem_ready, halt_req, resume;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, mem_wb_flush, halted, bus_error;
    logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;
    logic [9:0] obs_s;

    logic [9:0] sb_q[$];
    int total_cnt;
    int bad_cnt;
    longint unsigned m_cyc, m_stl, m_fl;

    pipeline_control_unit #(.MEM_TIMEOUT(8), .DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_use_stall (load_use_stall),
        .branch_taken   (branch_taken),
        .imem_ready     (imem_ready),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .halt_req       (halt_req),
        .resume         (resume),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .id_ex_en       (id_ex_en),
        .ex_mem_en      (ex_mem_en),
        .mem_wb_en      (mem_wb_en),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .mem_wb_flush   (mem_wb_flush),
        .halted         (halted),
        .bus_error      (bus_error),
        .cycle_cnt      (cycle_cnt),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    assign obs_s = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                    if_id_flush, id_ex_flush, mem_wb_flush, halted, bus_error};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard consumer: compare the control word mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            chk("ctl", {54'd0, obs_s}, {54'd0, sb_q.pop_front()});
        end
    end

    // Drive one cycle of inputs, queue its expected outputs, advance the counter model.
    task automatic step(input logic lu, input logic br, input logic im, input logic dr,
                        input logic dy, input logic hr, input logic rs, input logic [9:0] exp);
        load_use_stall = lu;
        branch_taken   = br;
        imem_ready     = im;
        dmem_req       = dr;
        dmem_ready     = dy;
        halt_req       = hr;
        resume         = rs;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        if (!exp[1]) begin
            m_cyc++;
            if (!exp[9]) m_stl++;
        end
        if (exp[9:2] == C_BR) m_fl++;
    endtask

    task automatic idle(input logic [9:0] exp);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exp);
    endtask

    task automatic check_cnt();
        chk("cycle_cnt", cycle_cnt, m_cyc);
        chk("stall_cnt", stall_cnt, m_stl);
        chk("flush_cnt", flush_cnt, m_fl);
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        m_cyc = 0; m_stl = 0; m_fl = 0;
        rst_n = 1'b0;
        load_use_stall = 1'b0; branch_taken = 1'b0; imem_ready = 1'b1;
        dmem_req = 1'b0; dmem_ready = 1'b0; halt_req = 1'b0; resume = 1'b0;
        #3;
        chk("rst_ctl", {54'd0, obs_s}, 64'd0);
        check_cnt();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // load-use bubble, then branch beating load-use and a missing fetch
        idle({C_DEF, 2'b00});
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {C_BUB, 2'b00});
        idle({C_DEF, 2'b00});
        check_cnt();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, {C_BR, 2'b00});
        check_cnt();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {C_BUB, 2'b00});

        // 4-cycle DMEM wait with a branch held, flushed on release
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {C_DMW, 2'b00});
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {C_DMW, 2'b00});
        end
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, {C_BR, 2'b00});
        idle({C_DEF, 2'b00});
        check_cnt();

        // halt: three drain cycles then halted, resume back to run
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {C_DRN, 2'b00});
        for (int i = 0; i < 3; i++) idle({C_DRN, 2'b00});
        idle({C_HLT, 2'b10});
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, {C_HLT, 2'b10});
        idle({C_DEF, 2'b00});
        check_cnt();

        // DMEM timeout after 8 waiting cycles
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {C_DMW, 2'b00});
        end
        idle({C_HLT, 2'b11});
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, {C_HLT, 2'b11});
        idle({C_DEF, 2'b00});
        check_cnt();

        // drain stretched by a 2-cycle DMEM wait
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {C_DRN, 2'b00});
        idle({C_DRN, 2'b00});
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {C_DMW, 2'b00});
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {C_DMW, 2'b00});
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, {C_DRN, 2'b00});
        idle({C_DRN, 2'b00});
        idle({C_HLT, 2'b10});
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, {C_HLT, 2'b10});
        check_cnt();

        // asynchronous reset in the middle of a drain
        idle({C_DEF, 2'b00});
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {C_DRN, 2'b00});
        idle({C_DRN, 2'b00});
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ctl", {54'd0, obs_s}, 64'd0);
        m_cyc = 0; m_stl = 0; m_fl = 0;
        check_cnt();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_cnt();
        idle({C_DEF, 2'b00});
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {C_BUB, 2'b00});
        idle({C_DEF, 2'b00});
        check_cnt();

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
